// File: rtl/alu_rs_pkg.sv
// Shared widths, ALU opcode encodings and reservation-station entry layout
// used by the issue queue and the ALU functional unit.
package alu_rs_pkg;

    localparam int DEF_SIZE       = 32;
    localparam int DEF_REG_NUM    = 64;
    localparam int DEF_ALUOP_BITS = 3;
    localparam int DEF_ROB_ROWS   = 16;
    localparam int DEF_RS_ENTRIES = 8;
    localparam int DEF_WB_PORTS   = 2;

    localparam int RW = $clog2(DEF_REG_NUM);
    localparam int TW = $clog2(DEF_ROB_ROWS);

    localparam logic [DEF_ALUOP_BITS-1:0] ALU_ADD = 3'd0;
    localparam logic [DEF_ALUOP_BITS-1:0] ALU_SUB = 3'd1;
    localparam logic [DEF_ALUOP_BITS-1:0] ALU_AND = 3'd2;
    localparam logic [DEF_ALUOP_BITS-1:0] ALU_XOR = 3'd3;
    localparam logic [DEF_ALUOP_BITS-1:0] ALU_SRA = 3'd4;

    typedef struct packed {
        logic [DEF_ALUOP_BITS-1:0] aluop;
        logic [RW-1:0]             s1;
        logic                      r1;
        logic [RW-1:0]             s2;
        logic                      r2;
        logic                      use_imm;
        logic [DEF_SIZE-1:0]       imm;
        logic [RW-1:0]             dest;
        logic [TW-1:0]             robn;
    } rs_entry_t;

endpackage

// File: rtl/rs_oldest_select.sv
// Age matrix over the queue slots; grants the single oldest eligible slot.
module rs_oldest_select
    import alu_rs_pkg::*;
#(
    parameter int RS_ENTRIES = DEF_RS_ENTRIES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_flush,
    input  logic [RS_ENTRIES-1:0] i_alloc_oh,
    input  logic [RS_ENTRIES-1:0] i_valid,
    input  logic [RS_ENTRIES-1:0] i_elig,
    output logic [RS_ENTRIES-1:0] o_grant
);

    // r_older[i][j] set means slot i was allocated before slot j
    logic [RS_ENTRIES-1:0] r_older [RS_ENTRIES];
    logic [RS_ENTRIES-1:0] w_blocked;

    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            for (int i = 0; i < RS_ENTRIES; i++) r_older[i] <= '0;
        end else begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                for (int j = 0; j < RS_ENTRIES; j++) begin
                    if (i_alloc_oh[i])
                        r_older[i][j] <= 1'b0;
                    else if (i_alloc_oh[j])
                        r_older[i][j] <= i_valid[i];
                end
            end
        end
    end

    // Stale bits from freed rows are harmless: only eligible rows can block
    always_comb begin
        w_blocked = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            for (int j = 0; j < RS_ENTRIES; j++) begin
                if (j != i && i_elig[j] && r_older[j][i]) w_blocked[i] = 1'b1;
            end
        end
        o_grant = i_elig & ~w_blocked;
    end

endmodule

// File: rtl/alu_issue_queue.sv
// ALU reservation station: buffers dispatched ops, tracks operand readiness
// from writeback wakeups and issues the oldest ready op to the ALU each cycle.
module alu_issue_queue
    import alu_rs_pkg::*;
#(
    parameter int SIZE       = DEF_SIZE,
    parameter int REG_NUM    = DEF_REG_NUM,
    parameter int ALUOP_BITS = DEF_ALUOP_BITS,
    parameter int ROB_ROWS   = DEF_ROB_ROWS,
    parameter int RS_ENTRIES = DEF_RS_ENTRIES,
    parameter int WB_PORTS   = DEF_WB_PORTS
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          flush,
    input  logic                                          disp_valid,
    output logic                                          disp_ready,
    input  logic [ALUOP_BITS-1:0]                         disp_aluop,
    input  logic [$clog2(REG_NUM)-1:0]                    disp_src_reg1,
    input  logic [$clog2(REG_NUM)-1:0]                    disp_src_reg2,
    input  logic                                          disp_src1_rdy,
    input  logic                                          disp_src2_rdy,
    input  logic                                          disp_use_imm,
    input  logic [SIZE-1:0]                               disp_imm,
    input  logic [$clog2(REG_NUM)-1:0]                    disp_dest_reg,
    input  logic [$clog2(ROB_ROWS)-1:0]                   disp_robn,
    input  logic [WB_PORTS-1:0]                           wb_valid,
    input  logic [WB_PORTS-1:0][$clog2(REG_NUM)-1:0]      wb_reg,
    input  logic                                          fu_ready,
    output logic [ALUOP_BITS-1:0]                         ALUOp,
    output logic [$clog2(REG_NUM)-1:0]                    src_reg1,
    output logic [$clog2(REG_NUM)-1:0]                    src_reg2,
    output logic                                          use_imm,
    output logic [SIZE-1:0]                               imm,
    output logic [$clog2(REG_NUM)-1:0]                    dest_reg1,
    output logic                                          issue,
    output logic [$clog2(ROB_ROWS)-1:0]                   in_robn,
    output logic [$clog2(RS_ENTRIES+1)-1:0]               count
);

    localparam int IW = $clog2(RS_ENTRIES);
    localparam int CW = $clog2(RS_ENTRIES + 1);

    rs_entry_t             r_ent [RS_ENTRIES];
    logic [RS_ENTRIES-1:0] r_valid;
    logic [CW-1:0]         r_count;
    logic                  r_issue;
    logic [ALUOP_BITS-1:0] r_aluop;
    logic [RW-1:0]         r_src1, r_src2, r_dest;
    logic                  r_use_imm;
    logic [SIZE-1:0]       r_imm;
    logic [TW-1:0]         r_robn;

    logic [RS_ENTRIES-1:0] w_wake1, w_wake2, w_elig, w_grant, w_alloc_oh;
    logic                  w_dwake1, w_dwake2, w_do_disp, w_do_issue;
    logic [IW-1:0]         w_free_idx, w_sel_idx;
    rs_entry_t             w_new;

    // Same-cycle writeback matches, used both for bypass eligibility and capture
    always_comb begin
        w_wake1  = '0;
        w_wake2  = '0;
        w_dwake1 = 1'b0;
        w_dwake2 = 1'b0;
        for (int p = 0; p < WB_PORTS; p++) begin
            if (wb_valid[p]) begin
                for (int i = 0; i < RS_ENTRIES; i++) begin
                    if (r_ent[i].s1 == wb_reg[p]) w_wake1[i] = 1'b1;
                    if (r_ent[i].s2 == wb_reg[p]) w_wake2[i] = 1'b1;
                end
                if (disp_src_reg1 == wb_reg[p]) w_dwake1 = 1'b1;
                if (disp_src_reg2 == wb_reg[p]) w_dwake2 = 1'b1;
            end
        end
    end

    always_comb begin
        w_free_idx = '0;
        for (int i = RS_ENTRIES - 1; i >= 0; i--)
            if (!r_valid[i]) w_free_idx = IW'(i);
        w_sel_idx = '0;
        for (int i = 0; i < RS_ENTRIES; i++)
            if (w_grant[i]) w_sel_idx = IW'(i);
        for (int i = 0; i < RS_ENTRIES; i++)
            w_elig[i] = r_valid[i] && (r_ent[i].r1 || w_wake1[i])
                        && (r_ent[i].r2 || w_wake2[i]) && fu_ready;
    end

    assign disp_ready = ~&r_valid;
    assign w_do_disp  = disp_valid && disp_ready && !flush;
    assign w_do_issue = |w_grant && !flush;
    assign w_alloc_oh = w_do_disp ? (RS_ENTRIES'(1) << w_free_idx) : '0;

    always_comb begin
        w_new.aluop   = disp_aluop;
        w_new.s1      = disp_src_reg1;
        w_new.r1      = disp_src1_rdy || w_dwake1;
        w_new.s2      = disp_src_reg2;
        w_new.r2      = disp_use_imm || disp_src2_rdy || w_dwake2;
        w_new.use_imm = disp_use_imm;
        w_new.imm     = disp_imm;
        w_new.dest    = disp_dest_reg;
        w_new.robn    = disp_robn;
    end

    rs_oldest_select #(.RS_ENTRIES(RS_ENTRIES)) u_select (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_flush    (flush),
        .i_alloc_oh (w_alloc_oh),
        .i_valid    (r_valid),
        .i_elig     (w_elig),
        .o_grant    (w_grant)
    );

    // Payload storage; validity lives in r_valid so no reset is needed here
    always_ff @(posedge clk) begin
        for (int i = 0; i < RS_ENTRIES; i++) begin
            if (w_wake1[i]) r_ent[i].r1 <= 1'b1;
            if (w_wake2[i]) r_ent[i].r2 <= 1'b1;
        end
        if (w_do_disp) r_ent[w_free_idx] <= w_new;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid   <= '0;
            r_count   <= '0;
            r_issue   <= 1'b0;
            r_aluop   <= '0;
            r_src1    <= '0;
            r_src2    <= '0;
            r_use_imm <= 1'b0;
            r_imm     <= '0;
            r_dest    <= '0;
            r_robn    <= '0;
        end else if (flush) begin
            r_valid <= '0;
            r_count <= '0;
            r_issue <= 1'b0;
        end else begin
            r_issue <= w_do_issue;
            if (w_do_issue) begin
                r_valid[w_sel_idx] <= 1'b0;
                r_aluop   <= r_ent[w_sel_idx].aluop;
                r_src1    <= r_ent[w_sel_idx].s1;
                r_src2    <= r_ent[w_sel_idx].s2;
                r_use_imm <= r_ent[w_sel_idx].use_imm;
                r_imm     <= r_ent[w_sel_idx].imm;
                r_dest    <= r_ent[w_sel_idx].dest;
                r_robn    <= r_ent[w_sel_idx].robn;
            end
            if (w_do_disp) r_valid[w_free_idx] <= 1'b1;
            r_count <= r_count + CW'(w_do_disp) - CW'(w_do_issue);
        end
    end

    assign issue     = r_issue;
    assign ALUOp     = r_aluop;
    assign src_reg1  = r_src1;
    assign src_reg2  = r_src2;
    assign use_imm   = r_use_imm;
    assign imm       = r_imm;
    assign dest_reg1 = r_dest;
    assign in_robn   = r_robn;
    assign count     = r_count;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed and randomised checks of alu_issue_queue against an age-ordered
// queue model of the reservation station.
module tb_alu_issue_queue;
    import alu_rs_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, flush, disp_valid, disp_ready;
    logic [2:0]  disp_aluop;
    logic [5:0]  disp_src_reg1, disp_src_reg2, disp_dest_reg;
    logic        disp_src1_rdy, disp_src2_rdy, disp_use_imm;
    logic [31:0] disp_imm;
    logic [3:0]  disp_robn;
    logic [1:0]  wb_valid;
    logic [1:0][5:0] wb_reg;
    logic        fu_ready;
    logic [2:0]  ALUOp;
    logic [5:0]  src_reg1, src_reg2, dest_reg1;
    logic        use_imm, issue;
    logic [31:0] imm;
    logic [3:0]  in_robn, count;

    always #5 clk = ~clk;

    alu_issue_queue dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_aluop(disp_aluop),
        .disp_src_reg1(disp_src_reg1), .disp_src_reg2(disp_src_reg2),
        .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
        .disp_use_imm(disp_use_imm), .disp_imm(disp_imm), .disp_dest_reg(disp_dest_reg),
        .disp_robn(disp_robn), .wb_valid(wb_valid), .wb_reg(wb_reg), .fu_ready(fu_ready),
        .ALUOp(ALUOp), .src_reg1(src_reg1), .src_reg2(src_reg2), .use_imm(use_imm),
        .imm(imm), .dest_reg1(dest_reg1), .issue(issue), .in_robn(in_robn), .count(count)
    );

    typedef struct {
        int unsigned op, s1, s2, imm, dest, robn;
        bit r1, r2, ui;
    } mop_t;

    // Oldest op sits at the front of the queue
    mop_t mq[$];
    int unsigned e_op, e_s1, e_s2, e_ui, e_imm, e_dest, e_robn, e_issue;
    int tests = 0;
    int fails = 0;

    function automatic bit woke(int unsigned r);
        for (int p = 0; p < 2; p++)
            if (wb_valid[p] && int'(wb_reg[p]) == int'(r)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step();
        int k;
        bit room;
        mop_t m;
        k = -1;
        room = mq.size() < 8;
        if (!rst_n) begin
            mq.delete();
            {e_op, e_s1, e_s2, e_ui, e_imm, e_dest, e_robn, e_issue} = '0;
            return;
        end
        if (flush) begin
            mq.delete();
            e_issue = 0;
            return;
        end
        if (fu_ready)
            for (int i = 0; i < mq.size(); i++)
                if (k < 0 && (mq[i].r1 || woke(mq[i].s1)) && (mq[i].r2 || woke(mq[i].s2))) k = i;
        for (int i = 0; i < mq.size(); i++) begin
            if (woke(mq[i].s1)) mq[i].r1 = 1'b1;
            if (woke(mq[i].s2)) mq[i].r2 = 1'b1;
        end
        if (k >= 0) begin
            e_op = mq[k].op; e_s1 = mq[k].s1; e_s2 = mq[k].s2; e_ui = mq[k].ui;
            e_imm = mq[k].imm; e_dest = mq[k].dest; e_robn = mq[k].robn; e_issue = 1;
            mq.delete(k);
        end else begin
            e_issue = 0;
        end
        if (disp_valid && room) begin
            m.op = disp_aluop; m.s1 = disp_src_reg1; m.s2 = disp_src_reg2;
            m.r1 = disp_src1_rdy || woke(disp_src_reg1);
            m.r2 = disp_use_imm || disp_src2_rdy || woke(disp_src_reg2);
            m.ui = disp_use_imm; m.imm = disp_imm; m.dest = disp_dest_reg; m.robn = disp_robn;
            mq.push_back(m);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; disp_valid = 0; fu_ready = 1; wb_valid = '0; wb_reg = '0;
        disp_aluop = '0; disp_src_reg1 = '0; disp_src_reg2 = '0; disp_src1_rdy = 0;
        disp_src2_rdy = 0; disp_use_imm = 0; disp_imm = '0; disp_dest_reg = '0; disp_robn = '0;
    endtask

    task automatic set_disp(int op, int s1, bit r1, int s2, bit r2, bit ui,
                            int unsigned iv, int dest, int robn);
        disp_valid = 1; disp_aluop = 3'(op); disp_src_reg1 = 6'(s1); disp_src1_rdy = r1;
        disp_src_reg2 = 6'(s2); disp_src2_rdy = r2; disp_use_imm = ui; disp_imm = iv;
        disp_dest_reg = 6'(dest); disp_robn = 4'(robn);
    endtask

    task automatic test_reset();
        logic [63:0] got;
        idle(); rst_n = 0;
        tick(); tick();
        rst_n = 1;
        got = {issue, ALUOp, src_reg1, src_reg2, use_imm, imm, dest_reg1, in_robn, count, disp_ready};
        tests++;
        if (got !== 64'h1) begin
            fails++; $display("FAIL reset_state: got %h want %h", got, 64'h1);
        end
    endtask

    task automatic test_basic_add();
        logic [26:0] got;
        set_disp(ALU_ADD, 3, 1, 4, 1, 0, 0, 10, 5);
        tick(); idle();
        tests++;
        if (issue !== 1'b0 || count !== 4'd1) begin
            fails++; $display("FAIL basic_after_dispatch: got issue=%0d count=%0d want 0/1", issue, count);
        end
        tick();
        got = {issue, src_reg1, src_reg2, dest_reg1, in_robn, count};
        tests++;
        if (got !== {1'b1, 6'd3, 6'd4, 6'd10, 4'd5, 4'd0} || ALUOp !== ALU_ADD) begin
            fails++; $display("FAIL basic_issue: got %h op=%0d want %h op=0", got, ALUOp,
                              {1'b1, 6'd3, 6'd4, 6'd10, 4'd5, 4'd0});
        end
    endtask

    task automatic test_wakeup_bypass();
        set_disp(ALU_SUB, 7, 0, 8, 1, 0, 0, 11, 1);
        tick();
        set_disp(ALU_AND, 9, 1, 12, 1, 0, 0, 13, 2);
        tick(); idle();
        tests++;
        if (issue !== 1'b0) begin
            fails++; $display("FAIL wake_none_yet: got issue=%0d want 0", issue);
        end
        tick();
        tests++;
        if (issue !== 1'b1 || in_robn !== 4'd2) begin
            fails++; $display("FAIL wake_b_first: got issue=%0d robn=%0d want 1/2", issue, in_robn);
        end
        wb_valid = 2'b01; wb_reg[0] = 6'd7;
        tick(); idle();
        tests++;
        if (issue !== 1'b1 || in_robn !== 4'd1 || ALUOp !== ALU_SUB) begin
            fails++; $display("FAIL wake_bypass_a: got issue=%0d robn=%0d op=%0d want 1/1/1",
                              issue, in_robn, ALUOp);
        end
        tick();
        tests++;
        if (issue !== 1'b0 || count !== 4'd0) begin
            fails++; $display("FAIL wake_drained: got issue=%0d count=%0d want 0/0", issue, count);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) begin
            set_disp(ALU_ADD, 20 + i, 0, 1, 1, 0, 0, i, i);
            tick();
        end
        idle();
        tests++;
        if (count !== 4'd8 || disp_ready !== 1'b0) begin
            fails++; $display("FAIL full_state: got count=%0d ready=%0d want 8/0", count, disp_ready);
        end
        set_disp(ALU_ADD, 1, 1, 2, 1, 0, 0, 0, 15);
        tick();
        tests++;
        if (count !== 4'd8 || issue !== 1'b0) begin
            fails++; $display("FAIL full_ignore: got count=%0d issue=%0d want 8/0", count, issue);
        end
        set_disp(ALU_ADD, 1, 1, 2, 1, 0, 0, 0, 14);
        wb_valid = 2'b10; wb_reg[1] = 6'd23;
        tick(); idle();
        tests++;
        if (issue !== 1'b1 || in_robn !== 4'd3 || count !== 4'd7 || disp_ready !== 1'b1) begin
            fails++; $display("FAIL full_wake_refuse: got issue=%0d robn=%0d count=%0d ready=%0d want 1/3/7/1",
                              issue, in_robn, count, disp_ready);
        end
        flush = 1;
        tick(); idle();
        tests++;
        if (count !== 4'd0) begin
            fails++; $display("FAIL full_cleanup: got count=%0d want 0", count);
        end
    endtask

    task automatic test_fu_stall();
        fu_ready = 0;
        for (int i = 0; i < 3; i++) begin
            set_disp(ALU_AND, 2, 1, 3, 1, 0, 0, i, 10 + i);
            tick();
        end
        disp_valid = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (issue !== 1'b0 || count !== 4'd3) begin
                fails++; $display("FAIL stall_hold: got issue=%0d count=%0d want 0/3", issue, count);
            end
        end
        fu_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (issue !== 1'b1 || in_robn !== 4'(10 + i)) begin
                fails++; $display("FAIL stall_release: got issue=%0d robn=%0d want 1/%0d",
                                  issue, in_robn, 10 + i);
            end
        end
        idle();
    endtask

    task automatic test_imm();
        logic [37:0] got;
        set_disp(ALU_XOR, 2, 1, 30, 0, 1, 32'hFFFF0000, 5, 7);
        tick(); idle(); tick();
        got = {issue, ALUOp, use_imm, imm, in_robn[0]};
        tests++;
        if (got !== {1'b1, ALU_XOR, 1'b1, 32'hFFFF0000, 1'b1} || in_robn !== 4'd7) begin
            fails++; $display("FAIL imm_issue: got %h robn=%0d want %h robn=7", got, in_robn,
                              {1'b1, ALU_XOR, 1'b1, 32'hFFFF0000, 1'b1});
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            set_disp(ALU_SRA, 40 + i, 0, 50, 0, 0, 0, i, i);
            tick();
        end
        set_disp(ALU_ADD, 1, 1, 2, 1, 0, 0, 0, 9);
        tick(); idle(); tick();
        tests++;
        if (issue !== 1'b1 || in_robn !== 4'd9 || count !== 4'd5) begin
            fails++; $display("FAIL flush_pre: got issue=%0d robn=%0d count=%0d want 1/9/5",
                              issue, in_robn, count);
        end
        flush = 1;
        set_disp(ALU_ADD, 1, 1, 2, 1, 0, 0, 0, 8);
        tick(); idle();
        tests++;
        if (count !== 4'd0 || issue !== 1'b0) begin
            fails++; $display("FAIL flush_clear: got count=%0d issue=%0d want 0/0", count, issue);
        end
        wb_valid = 2'b11; wb_reg[0] = 6'd40; wb_reg[1] = 6'd50;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (issue !== 1'b0 || count !== 4'd0) begin
                fails++; $display("FAIL flush_no_issue: got issue=%0d count=%0d want 0/0", issue, count);
            end
        end
        idle();
    endtask

    task automatic test_random();
        logic [63:0] got, exp;
        for (int c = 0; c < 500; c++) begin
            flush = ($urandom_range(0, 99) < 2);
            fu_ready = ($urandom_range(0, 99) < 80);
            disp_valid = ($urandom_range(0, 99) < 60);
            disp_aluop = 3'($urandom_range(0, 4));
            disp_src_reg1 = 6'($urandom_range(0, 7));
            disp_src_reg2 = 6'($urandom_range(0, 7));
            disp_src1_rdy = ($urandom_range(0, 3) == 0);
            disp_src2_rdy = ($urandom_range(0, 3) == 0);
            disp_use_imm = ($urandom_range(0, 4) == 0);
            disp_imm = $urandom;
            disp_dest_reg = 6'($urandom_range(0, 63));
            disp_robn = 4'($urandom_range(0, 15));
            for (int p = 0; p < 2; p++) begin
                wb_valid[p] = ($urandom_range(0, 99) < 30);
                wb_reg[p] = 6'($urandom_range(0, 7));
            end
            tick();
            got = {issue, ALUOp, src_reg1, src_reg2, use_imm, imm, dest_reg1, in_robn, count, disp_ready};
            exp = {1'(e_issue), 3'(e_op), 6'(e_s1), 6'(e_s2), 1'(e_ui), 32'(e_imm), 6'(e_dest),
                   4'(e_robn), 4'(mq.size()), 1'(mq.size() < 8)};
            tests++;
            if (got !== exp) begin
                fails++; $display("FAIL random_cycle%0d: got %h want %h", c, got, exp);
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        logic [62:0] got;
        for (int i = 0; i < 4; i++) begin
            set_disp(ALU_SUB, 1, 1, 2, 1, 0, 32'hA5A5_0000 + i, 60, 12 + i);
            tick();
        end
        rst_n = 0;
        tick();
        rst_n = 1; idle();
        got = {issue, ALUOp, src_reg1, src_reg2, use_imm, imm, dest_reg1, in_robn, count};
        tests++;
        if (got !== '0) begin
            fails++; $display("FAIL reset_mid: got %h want 0", got);
        end
        tick();
        tests++;
        if (issue !== 1'b0 || count !== 4'd0 || disp_ready !== 1'b1) begin
            fails++; $display("FAIL reset_mid_after: got issue=%0d count=%0d ready=%0d want 0/0/1",
                              issue, count, disp_ready);
        end
    endtask

    initial begin
        rst_n = 0;
        idle();
        test_reset();
        test_basic_add();
        test_wakeup_bypass();
        test_full();
        test_fu_stall();
        test_imm();
        test_flush();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
